// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types for the L1 memory arbiter: return-queue entry and arbiter FSM state.
package l1_arb_types;
  localparam int L1_ARB_NUM_REQ = 4;
  localparam int L1_ARB_SIZE_W  = 5;
  localparam int L1_ARB_ID_W    = $clog2(L1_ARB_NUM_REQ);

  typedef struct packed {
    logic [L1_ARB_ID_W-1:0]   id;
    logic [L1_ARB_SIZE_W-1:0] size;
  } ret_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/l1_mem_arbiter_ret_fifo.sv
// In-order return queue of accepted reads; head is visible combinationally.
module l1_arb_ret_fifo
  import l1_arb_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ret_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output ret_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  ret_entry_t       entries [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // The extra wrap bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr_reg[AW-1:0]] <= push_entry;
  end
endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among L1 requesters, with
// in-order routing of returning read bursts to their owners.
module l1_mem_arbiter
  import l1_arb_types::*;
#(
  parameter int NUM_REQ   = L1_ARB_NUM_REQ,
  parameter int RET_DEPTH = 4,
  parameter int SIZE_W    = L1_ARB_SIZE_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_request,
  input  logic [NUM_REQ-1:0][31:0]       req_addr,
  input  logic [NUM_REQ-1:0]             req_rnw,
  input  logic [NUM_REQ-1:0][SIZE_W-1:0] req_size,
  input  logic [NUM_REQ-1:0][31:0]       req_data,
  input  logic [NUM_REQ-1:0][3:0]        req_be,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             rsp_data_valid,
  output logic [31:0]                    rsp_data,
  output logic                           mem_request,
  output logic [31:0]                    mem_addr,
  output logic                           mem_rnw,
  output logic [SIZE_W-1:0]              mem_size,
  output logic [31:0]                    mem_data,
  output logic [3:0]                     mem_be,
  input  logic                           mem_ack,
  input  logic                           mem_rd_data_valid,
  input  logic [31:0]                    mem_rd_data
);
  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t        state_reg;
  logic [ID_W-1:0]   grant_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   grant_next;
  logic [SIZE_W-1:0] word_cnt_reg;
  logic [NUM_REQ-1:0] eligible;
  logic              accept;
  logic              rd_valid;
  logic              last_word;
  logic              fifo_full;
  logic              fifo_empty;
  ret_entry_t        fifo_head;
  ret_entry_t        push_entry;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [ID_W-1:0]    ptr);
    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    idx;
    rot = NUM_REQ'({elig, elig} >> ptr);
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = ID_W'(i);
    end
    return ID_W'((32'(idx) + 32'(ptr)) % NUM_REQ);
  endfunction

  // Reads are held back while the return queue cannot take another entry.
  assign eligible   = req_request & ~(req_rnw & {NUM_REQ{fifo_full}});
  assign accept     = (state_reg == GRANT) && mem_ack;
  assign grant_next = (32'(grant_reg) == NUM_REQ - 1) ? '0 : grant_reg + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|eligible) begin
            grant_reg <= rr_pick(eligible, rr_ptr_reg);
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          if (mem_ack) begin
            rr_ptr_reg <= grant_next;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_request = (state_reg == GRANT);
  assign mem_addr    = req_addr[grant_reg];
  assign mem_rnw     = req_rnw[grant_reg];
  assign mem_size    = req_size[grant_reg];
  assign mem_data    = req_data[grant_reg];
  assign mem_be      = req_be[grant_reg];

  assign push_entry = '{id: grant_reg, size: mem_size};

  l1_arb_ret_fifo #(
    .DEPTH(RET_DEPTH)
  ) u_ret_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && mem_rnw),
    .push_entry(push_entry),
    .pop       (last_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // A word arriving with nothing outstanding has no owner and is dropped.
  assign rd_valid  = mem_rd_data_valid && !fifo_empty;
  assign last_word = rd_valid && (word_cnt_reg == fifo_head.size);
  assign rsp_data  = mem_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_reg <= '0;
    end else if (rd_valid) begin
      word_cnt_reg <= last_word ? '0 : word_cnt_reg + SIZE_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_route
    assign req_ack[gi]        = accept && (grant_reg == ID_W'(gi));
    assign rsp_data_valid[gi] = rd_valid && (fifo_head.id == ID_W'(gi));
  end

  rd_when_empty: assert property (@(posedge clk) disable iff (rst)
                                  !(mem_rd_data_valid && fifo_empty));
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: table-driven single read, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_l1_mem_arbiter;
  typedef struct { int id; int size; } ent_t;
  typedef struct {
    logic req; logic mack; logic rdv; logic [31:0] rdd;
    logic [3:0] exp_ack; logic [3:0] exp_rv; logic exp_mreq;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_request, req_rnw, req_ack, rsp_data_valid;
  logic [3:0][31:0] req_addr, req_data;
  logic [3:0][4:0] req_size;
  logic [3:0][3:0] req_be;
  logic [31:0] rsp_data, mem_addr, mem_data, mem_rd_data;
  logic mem_request, mem_rnw, mem_ack, mem_rd_data_valid;
  logic [4:0] mem_size;
  logic [3:0] mem_be;

  int total = 0;
  int bad = 0;
  ent_t m_q[$];
  bit m_busy;
  int m_grant, m_rr, m_cnt;
  logic [3:0] ack_seen;
  vec_t tbl[14];

  l1_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_request(req_request), .req_addr(req_addr), .req_rnw(req_rnw),
    .req_size(req_size), .req_data(req_data), .req_be(req_be),
    .req_ack(req_ack), .rsp_data_valid(rsp_data_valid), .rsp_data(rsp_data),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_rnw(mem_rnw),
    .mem_size(mem_size), .mem_data(mem_data), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int rr_winner(input logic [3:0] e, input int start);
    for (int k = 0; k < 4; k++) if (e[(start + k) % 4]) return (start + k) % 4;
    return 0;
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Checks this cycle's outputs against the model, then advances the model past the edge.
  task automatic settle();
    logic [3:0] elig, exp_ack, exp_rv;
    #2;
    if (rst) begin
      m_q.delete(); m_busy = 0; m_cnt = 0; m_rr = 0; m_grant = 0;
      return;
    end
    elig = req_request & ~(req_rnw & {4{m_q.size() == 4}});
    chk("mem_request", mem_request, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr, req_addr[m_grant]);
      chk("mem_ctl", {mem_rnw, mem_size, mem_be}, {req_rnw[m_grant], req_size[m_grant], req_be[m_grant]});
      chk("mem_data", mem_data, req_data[m_grant]);
    end
    exp_ack = (m_busy && mem_ack) ? 4'(1 << m_grant) : 4'b0;
    exp_rv  = (mem_rd_data_valid && m_q.size() != 0) ? 4'(1 << m_q[0].id) : 4'b0;
    chk("req_ack", req_ack, exp_ack);
    chk("rsp_valid", rsp_data_valid, exp_rv);
    if (mem_rd_data_valid) chk("rsp_data", rsp_data, mem_rd_data);
    if (mem_rd_data_valid && m_q.size() != 0) begin
      if (m_cnt == m_q[0].size) begin
        void'(m_q.pop_front());
        m_cnt = 0;
      end else m_cnt++;
    end
    if (m_busy && mem_ack) begin
      m_rr = (m_grant + 1) % 4;
      if (req_rnw[m_grant]) m_q.push_back('{m_grant, int'(req_size[m_grant])});
      m_busy = 0;
    end else if (!m_busy && elig != 4'b0) begin
      m_grant = rr_winner(elig, m_rr);
      m_busy = 1;
    end
  endtask

  task automatic cyc_drop();
    settle();
    ack_seen = ack_seen | req_ack;
    for (int i = 0; i < 4; i++) if (req_ack[i]) req_request[i] = 1'b0;
    adv();
  endtask

  task automatic set_req(input int id, input logic rnw, input logic [31:0] addr, input int size);
    req_request[id] = 1'b1;
    req_rnw[id] = rnw;
    req_addr[id] = addr;
    req_size[id] = 5'(size);
    req_data[id] = addr ^ 32'hA5A5_0000;
    req_be[id] = 4'($urandom_range(15));
  endtask

  task automatic do_req(input int id, input logic rnw, input logic [31:0] addr, input int size);
    set_req(id, rnw, addr, size);
    ack_seen = '0;
    for (int k = 0; k < 20 && !ack_seen[id]; k++) begin
      mem_ack = mem_request;
      cyc_drop();
    end
    mem_ack = 1'b0;
    chk("req_ack_timeout", ack_seen[id], 1'b1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_q.size() == 0 && !m_busy && req_request == 4'b0) begin
        done = 1;
        break;
      end
      mem_ack = mem_request;
      mem_rd_data_valid = (m_q.size() != 0);
      mem_rd_data = $urandom;
      cyc_drop();
    end
    mem_ack = 1'b0;
    mem_rd_data_valid = 1'b0;
    chk("drain_timeout", done, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_request = '0; mem_ack = 1'b0; mem_rd_data_valid = 1'b0;
    settle(); adv(); settle(); adv();
    rst = 1'b0;
    settle();
    chk("reset_ack", req_ack, 4'b0);
    chk("reset_rvalid", rsp_data_valid, 4'b0);
    chk("reset_mreq", mem_request, 1'b0);
    adv();
  endtask

  initial begin
    int order[$];
    rst = 1'b1; req_request = '0; req_rnw = '0; req_addr = '0; req_size = '0;
    req_data = '0; req_be = '0; mem_ack = 1'b0; mem_rd_data_valid = 1'b0; mem_rd_data = '0;
    ack_seen = '0;
    adv();
    do_reset();

    // Single read, req 0, size 7, mem_ack two cycles after mem_request
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0, 4'b0001, 4'b0000, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 1'b0};
    for (int w = 0; w < 8; w++)
      tbl[5 + w] = '{1'b0, 1'b0, 1'b1, 32'hA0 + 32'(w), 4'b0000, 4'b0001, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 1'b0};
    set_req(0, 1'b1, 32'h100, 7);
    for (int i = 0; i < 14; i++) begin
      req_request[0] = tbl[i].req; mem_ack = tbl[i].mack;
      mem_rd_data_valid = tbl[i].rdv; mem_rd_data = tbl[i].rdd;
      settle();
      chk("t1_mreq", mem_request, tbl[i].exp_mreq);
      chk("t1_ack", req_ack, tbl[i].exp_ack);
      chk("t1_rvalid", rsp_data_valid, tbl[i].exp_rv);
      adv();
    end

    // Four held writes, immediate mem_ack: grant order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h1000 + 32'(i * 16), 0);
    for (int k = 0; k < 12; k++) begin
      mem_ack = mem_request;
      settle();
      if (req_ack != 4'b0) order.push_back($clog2(req_ack));
      adv();
    end
    req_request = '0; mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) chk("t2_order", (order.size() > k) ? order[k] : -1, k % 4);

    // Two reads accepted before any data: 4 words to req 1, then 1 to req 2
    do_reset();
    set_req(1, 1'b1, 32'h310, 3);
    set_req(2, 1'b1, 32'h320, 0);
    ack_seen = '0;
    for (int k = 0; k < 10 && ack_seen[2:1] != 2'b11; k++) begin
      mem_ack = mem_request;
      cyc_drop();
    end
    mem_ack = 1'b0;
    chk("t3_both_acked", ack_seen[2:1], 2'b11);
    for (int w = 0; w < 5; w++) begin
      mem_rd_data_valid = 1'b1; mem_rd_data = 32'hC0 + 32'(w);
      settle();
      chk("t3_route", rsp_data_valid, (w < 4) ? 4'b0010 : 4'b0100);
      adv();
    end
    mem_rd_data_valid = 1'b0;

    // Queue full: write still granted, read waits until the head burst pops
    do_reset();
    for (int i = 0; i < 4; i++) do_req(i, 1'b1, 32'h400 + 32'(i * 16), 1);
    set_req(3, 1'b1, 32'h4F0, 0);
    set_req(0, 1'b0, 32'h4E0, 0);
    ack_seen = '0;
    for (int k = 0; k < 6; k++) begin
      mem_ack = mem_request;
      cyc_drop();
    end
    mem_ack = 1'b0;
    chk("t4_write_granted", ack_seen[0], 1'b1);
    chk("t4_read_held", ack_seen[3], 1'b0);
    for (int w = 0; w < 2; w++) begin
      mem_rd_data_valid = 1'b1; mem_rd_data = 32'hD0 + 32'(w);
      settle(); adv();
    end
    mem_rd_data_valid = 1'b0;
    settle();
    chk("t4_idle_arb", mem_request, 1'b0);
    adv();
    mem_ack = mem_request;
    settle();
    chk("t4_grant_req", mem_request, 1'b1);
    chk("t4_grant_addr", mem_addr, 32'h4F0);
    chk("t4_ack3", req_ack, 4'b1000);
    req_request[3] = 1'b0;
    adv();
    drain();

    // Reset on word 3 of an 8-word burst, then fresh reads complete cleanly
    do_reset();
    do_req(1, 1'b1, 32'h510, 7);
    for (int w = 0; w < 3; w++) begin
      mem_rd_data_valid = 1'b1; mem_rd_data = 32'hE0 + 32'(w);
      settle(); adv();
    end
    rst = 1'b1; mem_rd_data = 32'hE3;
    settle(); adv();
    rst = 1'b0; mem_rd_data_valid = 1'b0;
    settle();
    chk("t5_ack", req_ack, 4'b0);
    chk("t5_rvalid", rsp_data_valid, 4'b0);
    chk("t5_mreq", mem_request, 1'b0);
    adv();
    do_req(2, 1'b1, 32'h520, 1);
    do_req(0, 1'b1, 32'h500, 0);
    for (int w = 0; w < 3; w++) begin
      mem_rd_data_valid = 1'b1; mem_rd_data = 32'hF0 + 32'(w);
      settle();
      chk("t5_route", rsp_data_valid, (w < 2) ? 4'b0100 : 4'b0001);
      adv();
    end
    mem_rd_data_valid = 1'b0;

    // Read accepted in the same cycle the head burst's last word pops
    do_reset();
    do_req(0, 1'b1, 32'h600, 1);
    do_req(1, 1'b1, 32'h610, 0);
    do_req(3, 1'b1, 32'h630, 0);
    set_req(2, 1'b1, 32'h620, 0);
    mem_rd_data_valid = 1'b1; mem_rd_data = 32'hB0;
    settle();
    chk("t6_w0_route", rsp_data_valid, 4'b0001);
    chk("t6_arb_idle", mem_request, 1'b0);
    adv();
    mem_ack = 1'b1; mem_rd_data = 32'hB1;
    settle();
    chk("t6_push_ack", req_ack, 4'b0100);
    chk("t6_pop_route", rsp_data_valid, 4'b0001);
    req_request[2] = 1'b0;
    adv();
    mem_ack = 1'b0; mem_rd_data_valid = 1'b0;
    do_req(1, 1'b1, 32'h640, 0);
    set_req(0, 1'b1, 32'h650, 0);
    ack_seen = '0;
    for (int k = 0; k < 5; k++) begin
      mem_ack = mem_request;
      cyc_drop();
    end
    chk("t6_full_block", ack_seen[0], 1'b0);
    drain();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!req_request[i] && $urandom_range(3) == 0)
          set_req(i, 1'($urandom_range(1)), $urandom, int'($urandom_range(3)));
      mem_ack = mem_request & 1'($urandom_range(1));
      mem_rd_data_valid = (m_q.size() != 0) && ($urandom_range(1) == 1);
      mem_rd_data = $urandom;
      cyc_drop();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
